instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Inverse of the immediate generator. Packs decoded fields (opcode class, registers, funct, 12-bit imm)
//  into a 32-bit RISC-V word (R, I-load, S, SB formats).
//  Buffers encoded words in a small FIFO and tags each with an instruction-memory byte address.
//  Feeds the instruction-memory loader and the program-image builder in test benches.
// PARAMETERS
//  FIFO_DEPTH  2      output FIFO entries; power of 2, >=2
//  ADDR_W      32     width of out_addr
//  BASE_ADDR   0      address given to the first word after reset/clear
// PORTS
//  clk       in   1       clock, rising edge
//  reset     in   1       asynchronous, active-high reset
//  clear     in   1       sync: empty FIFO, address counter := BASE_ADDR
//  in_valid  in   1       request valid
//  in_ready  out  1       request accepted when in_valid && in_ready
//  fmt       in   2       00 R(0110011), 01 I-load(0000011), 10 S(0100011), 11 SB(1100011)
//  rd/rs1/rs2 in  5 each  register fields
//  funct3    in   3       funct3 field
//  funct7    in   7       funct7 field (R only)
//  imm       in   12      immediate; SB: imm = offset[12:1]
//  out_valid out  1       FIFO head valid
//  out_ready in   1       consumer pop
//  out_instr out  32      encoded word at FIFO head
//  out_addr  out  ADDR_W  byte address of out_instr
//  err       out  1       one-cycle pulse: request rejected (macro only)
// BEHAVIOUR
//  Reset (async): FIFO empty, out_valid=0, out_instr=0, out_addr=BASE_ADDR, err=0, addr counter=BASE_ADDR.
//  Encoding:
//    R  = {funct7,rs2,rs1,funct3,rd,op}
//    I  = {imm,rs1,funct3,rd,op}
//    S  = {imm[11:5],rs2,rs1,funct3,imm[4:0],op}
//    SB = {imm[11],imm[9:4],rs2,rs1,funct3,imm[3:0],imm[10],op}
//  Unused fields are ignored.
//  in_ready = !full && !clear. Push on accept; word written with current addr counter; counter += 4.
//  Counter wraps modulo 2^ADDR_W.
//  Latency: word accepted at edge N is visible with out_valid=1 after edge N (no bypass when empty).
//  Pop when out_valid && out_ready. out_instr/out_addr hold while out_valid && !out_ready.
//  Full: in_ready=0 even if a pop happens in the same cycle (no simultaneous push into a full FIFO).
//  Non-full, push+pop in the same cycle: occupancy unchanged, order preserved.
//  Empty: out_valid=0; out_instr/out_addr show the last popped value (don't-care).
//  clear wins over push and pop in the same cycle; takes effect at the next edge.
//  reset mid-transfer: in-flight entries are lost; no err pulse.
//  Pointers: log2(FIFO_DEPTH) bits plus a wrap bit for full/empty detection.
// CONFIGURATION
//  ENC_ERR_CHECK_EN defined: a request is illegal if
//    - fmt=R with funct7 not 0000000/0100000, or
//    - fmt=SB with funct3 = 010 or 011.
//  Illegal requests are accepted (handshake completes), not pushed, counter not advanced,
//  and err=1 for the cycle after acceptance.
//  ENC_ERR_CHECK_EN undefined: err tied 0; every request is encoded as-is.
// TESTING
//  1 LW: fmt=01 imm=12'b010101010101 rs1=31 funct3=010 rd=31
//      -> out_instr=32'h555FAF83, out_addr=BASE_ADDR, 1 cycle later.
//  2 SW: fmt=10 imm=12'b010101010101 rs2=31 rs1=31 funct3=010
//      -> 32'h55FFAAA3; out_addr=BASE_ADDR+4 after test 1.
//  3 BEQ: fmt=11 imm=12'hFFF rs1=rs2=0 funct3=000 -> 32'hFE000FE3; imm=0 -> 32'h00000063.
//  4 Backpressure: out_ready=0, push 3 words with FIFO_DEPTH=2
//      -> in_ready=0 after 2; release -> 3 words in order, addrs +0/+4/+8.
//  5 clear asserted with FIFO full and in_valid=1 -> next cycle out_valid=0, next word at BASE_ADDR;
//    reset mid-stream -> all outputs at reset values immediately.
//  6 ENC_ERR_CHECK_EN: R with funct7=7'h01 -> err pulse, nothing pushed, address unchanged;
//    without macro -> encodes 32'h02...33 as-is.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RISC-V fields (R, I-load, S, SB) into a 32-bit
// instruction word and queues it, tagged with its instruction-memory byte address,
// in a small output FIFO.
// Optional feature macro: ENC_ERR_CHECK_EN. When defined, it rejects illegal
// funct7 (R) and funct3 (SB) requests and pulses err.
module instr_encoder #(
  parameter int                FIFO_DEPTH = 2,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [11:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0000011;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_SB = 7'b1100011;

  // Field packing for the four supported formats; fields a format does not use are ignored.
  function automatic logic [31:0] encode(
    input logic [1:0]  f,
    input logic [4:0]  f_rd,
    input logic [4:0]  f_rs1,
    input logic [4:0]  f_rs2,
    input logic [2:0]  f_f3,
    input logic [6:0]  f_f7,
    input logic [11:0] f_imm
  );
    logic [31:0] w;
    case (f)
      2'b00:   w = {f_f7, f_rs2, f_rs1, f_f3, f_rd, OP_R};
      2'b01:   w = {f_imm, f_rs1, f_f3, f_rd, OP_I};
      2'b10:   w = {f_imm[11:5], f_rs2, f_rs1, f_f3, f_imm[4:0], OP_S};
      default: w = {f_imm[11], f_imm[9:4], f_rs2, f_rs1, f_f3, f_imm[3:0], f_imm[10], OP_SB};
    endcase
    return w;
  endfunction

  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       instr_mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] addr_mem_q  [FIFO_DEPTH];

  logic empty, full, accept, legal, push, pop;

  // The wrap bit tells full (same index, different lap) from empty (identical pointers).
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                  (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  // A full FIFO refuses pushes even when it is being popped in the same cycle.
  assign in_ready  = !full && !clear;
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready && !clear;

  assign out_instr = instr_mem_q[rd_ptr_q[PTR_W-1:0]];
  assign out_addr  = addr_mem_q[rd_ptr_q[PTR_W-1:0]];

`ifdef ENC_ERR_CHECK_EN
  // R needs funct7 0000000/0100000; SB has no branch encoded with funct3 010/011.
  function automatic logic req_legal(
    input logic [1:0] f,
    input logic [6:0] f_f7,
    input logic [2:0] f_f3
  );
    logic ok;
    ok = 1'b1;
    if (f == 2'b00 && !(f_f7 == 7'h00 || f_f7 == 7'h20)) ok = 1'b0;
    if (f == 2'b11 && (f_f3 == 3'b010 || f_f3 == 3'b011)) ok = 1'b0;
    return ok;
  endfunction

  logic err_q;

  assign legal = req_legal(fmt, funct7, funct3);
  assign err   = err_q;

  // One-cycle error pulse after an illegal request completes its handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= accept && !legal;
  end
`else
  assign legal = 1'b1;
  assign err   = 1'b0;
`endif

  // Pointer and address-counter next state; clear overrides push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    addr_d   = addr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      addr_d   = BASE_ADDR;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        addr_d   = addr_q + ADDR_W'(4);
      end
      if (pop) rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    end
  end

  // Control state: FIFO pointers and the wrapping byte-address counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      addr_q   <= BASE_ADDR;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      addr_q   <= addr_d;
    end
  end

  // FIFO storage; reset so the head reads 0 / BASE_ADDR straight out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        addr_mem_q[i]  <= BASE_ADDR;
      end
    end else if (push) begin
      instr_mem_q[wr_ptr_q[PTR_W-1:0]] <= encode(fmt, rd, rs1, rs2, funct3, funct7, imm);
      addr_mem_q[wr_ptr_q[PTR_W-1:0]]  <= addr_q;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: directed vectors plus random traffic, checked
// cycle by cycle against a queue-based reference model.
module tb_instr_encoder;

  localparam int          DEPTH = 2;
  localparam logic [31:0] BASE  = 32'h0;

  logic        clk = 1'b0;
  logic        reset, clear, in_valid, out_ready;
  logic        in_ready, out_valid, err;
  logic [1:0]  fmt;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [11:0] imm;
  logic [31:0] out_instr;
  logic [31:0] out_addr;

  instr_encoder #(.FIFO_DEPTH(DEPTH), .ADDR_W(32), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_addr;
  logic        m_err;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference encoding built from the ISA bit positions with plain arithmetic.
  function automatic logic [31:0] m_enc(input logic [1:0] f, input logic [4:0] d, input logic [4:0] s1,
                                        input logic [4:0] s2, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [11:0] im);
    int unsigned w, off, ii;
    ii = im;
    w  = (32'(s1) << 15) + (32'(f3) << 12);
    case (f)
      2'd0: w = w + (32'(f7) << 25) + (32'(s2) << 20) + (32'(d) << 7) + 32'h33;
      2'd1: w = w + (ii << 20) + (32'(d) << 7) + 32'h03;
      2'd2: w = w + ((ii / 32) << 25) + (32'(s2) << 20) + ((ii % 32) << 7) + 32'h23;
      default: begin
        off = ii * 2;  // byte offset, bit 0 always zero
        w = w + (((off >> 12) & 1) << 31) + (((off >> 5) & 63) << 25) + (32'(s2) << 20)
              + (((off >> 1) & 15) << 8) + (((off >> 11) & 1) << 7) + 32'h63;
      end
    endcase
    return w;
  endfunction

  function automatic bit m_legal(input logic [1:0] f, input logic [6:0] f7, input logic [2:0] f3);
`ifdef ENC_ERR_CHECK_EN
    if (f == 2'd0 && f7 != 7'd0 && f7 != 7'd32) return 1'b0;
    if (f == 2'd3 && (f3 == 3'd2 || f3 == 3'd3)) return 1'b0;
`endif
    return 1'b1;
  endfunction

  task automatic set_req(input logic [1:0] f, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [11:0] im);
    fmt = f; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
  endtask

  // One clock: compare outputs with the model, clock the DUT, advance the model.
  task automatic step();
    bit exp_ready, exp_valid, acc, pop;
    #1;
    exp_ready = (q.size() < DEPTH) && !clear;
    exp_valid = (q.size() != 0);
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("out_valid", 32'(out_valid), 32'(exp_valid));
    chk("err", 32'(err), 32'(m_err));
    if (exp_valid) begin
      chk("out_instr", out_instr, q[0].instr);
      chk("out_addr", out_addr, q[0].addr);
    end
    acc = in_valid && exp_ready;
    pop = exp_valid && out_ready && !clear;
    @(posedge clk);
    #1;
    m_err = 1'b0;
    if (clear) begin
      q.delete();
      m_addr = BASE;
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        if (m_legal(fmt, funct7, funct3)) begin
          q.push_back('{instr: m_enc(fmt, rd, rs1, rs2, funct3, funct7, imm), addr: m_addr});
          m_addr = m_addr + 32'd4;
        end else begin
          m_err = 1'b1;
        end
      end
    end
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (DEPTH + 1) step();
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    fmt = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
    m_addr = BASE; m_err = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", out_addr, BASE);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b0;

    // LW, then SW, then the two BEQ vectors, each drained before the next.
    set_req(2'b01, 5'd31, 5'd31, 5'd0, 3'b010, 7'd0, 12'b010101010101);
    step(); in_valid = 1'b0;
    chk("lw_word", out_instr, 32'h555FAF83);
    chk("lw_addr", out_addr, BASE);
    drain();
    set_req(2'b10, 5'd0, 5'd31, 5'd31, 3'b010, 7'd0, 12'b010101010101);
    step(); in_valid = 1'b0;
    chk("sw_word", out_instr, 32'h55FFAAA3);
    chk("sw_addr", out_addr, BASE + 32'd4);
    drain();
    set_req(2'b11, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 12'hFFF);
    step(); in_valid = 1'b0;
    chk("beq_fff", out_instr, 32'hFE000FE3);
    drain();
    set_req(2'b11, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 12'h000);
    step(); in_valid = 1'b0;
    chk("beq_0", out_instr, 32'h00000063);
    drain();

    // Backpressure: two words fill the FIFO, a third waits until a pop frees a slot.
    set_req(2'b00, 5'd1, 5'd2, 5'd3, 3'b000, 7'h20, 12'd0); step();
    set_req(2'b01, 5'd4, 5'd5, 5'd0, 3'b000, 7'd0, 12'h123); step();
    set_req(2'b10, 5'd0, 5'd6, 5'd7, 3'b010, 7'd0, 12'h7F0);
    step();
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1; step();
    out_ready = 1'b0; step();
    in_valid = 1'b0; step();
    drain();

    // Push and pop together with one word stored: occupancy holds at one.
    set_req(2'b01, 5'd9, 5'd10, 5'd0, 3'b011, 7'd0, 12'h0AB); step();
    out_ready = 1'b1;
    set_req(2'b10, 5'd0, 5'd11, 5'd12, 3'b001, 7'd0, 12'h3C3); step();
    in_valid = 1'b0; out_ready = 1'b0; step();
    drain();

    // clear with a full FIFO and a pending request wins over the push.
    set_req(2'b01, 5'd1, 5'd1, 5'd0, 3'b000, 7'd0, 12'h001); step(); step();
    clear = 1'b1; out_ready = 1'b1; step();
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("clr_out_valid", 32'(out_valid), 32'd0);
    set_req(2'b01, 5'd2, 5'd3, 5'd0, 3'b010, 7'd0, 12'h010); step(); in_valid = 1'b0;
    chk("clr_addr_base", out_addr, BASE);
    step();

    // Asynchronous reset mid-stream.
    set_req(2'b00, 5'd5, 5'd6, 5'd7, 3'b000, 7'd0, 12'd0); step(); in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_instr", out_instr, 32'd0);
    chk("arst_out_addr", out_addr, BASE);
    chk("arst_err", 32'(err), 32'd0);
    reset = 1'b0;
    q.delete(); m_addr = BASE; m_err = 1'b0;
    step();

    // R with funct7=1: rejected with the error check, encoded as-is without it.
    set_req(2'b00, 5'd0, 5'd0, 5'd0, 3'b000, 7'h01, 12'd0); step(); in_valid = 1'b0;
`ifdef ENC_ERR_CHECK_EN
    chk("illegal_err", 32'(err), 32'd1);
    chk("illegal_nopush", 32'(out_valid), 32'd0);
    step();
    chk("illegal_err_pulse", 32'(err), 32'd0);
`else
    chk("r_f7_word", out_instr, 32'h02000033);
    chk("r_f7_addr", out_addr, BASE);
`endif
    drain();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      fmt       = 2'($urandom);
      rd        = 5'($urandom);
      rs1       = 5'($urandom);
      rs2       = 5'($urandom);
      funct3    = 3'($urandom);
      funct7    = ($urandom_range(0, 3) == 0) ? 7'($urandom) : (($urandom % 2) ? 7'h20 : 7'h00);
      imm       = 12'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clear     = ($urandom_range(0, 40) == 0);
      step();
    end
    clear = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
